token_stream_arbiter: RTL and testbench

Multi-lane serial token scheduler in the sequential-basics datapath. Each of N_LANES serial inputs delivers '1' tokens. Every accepted token is multiplied into MULT pending output tokens, held in a per-lane credit counter. A single shared serial output drains one token per cycle, and a round-robin arbiter shares that output between lanes. Lanes that exceed their pending budget raise a sticky per-lane overflow flag and are isolated.

---
 rtl/token_stream_arbiter.sv | 122 ++++++++++++
 tb/tb_token_stream_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_stream_arbiter.sv
// Multi-lane token credit scheduler with a shared round-robin serial drain.
// Optional TOKEN_ARB_LANE0_PRIORITY_EN gives lane 0 strict priority.
module token_stream_arbiter #(
  parameter int N_LANES     = 4,
  parameter int MULT        = 2,
  parameter int MAX_PENDING = 400,
  parameter int CNT_W       = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_LANES-1:0]         a,
  output logic                       b,
  output logic [$clog2(N_LANES)-1:0] grant,
  output logic                       busy,
  output logic [N_LANES-1:0]         overflow
);

  localparam int IW = $clog2(N_LANES);
  localparam int SW = CNT_W + 2;

  logic [CNT_W-1:0]   pend_q [N_LANES];
  logic [CNT_W-1:0]   pend_d [N_LANES];
  logic [SW-1:0]      nxt    [N_LANES];
  logic [N_LANES-1:0] ovf_q;
  logic [N_LANES-1:0] ovf_d;
  logic [N_LANES-1:0] req;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      ptr_d;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic               b_q;
  logic [IW-1:0]      grant_q;
  logic               busy_q;
  logic               busy_d;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      req[i] = (pend_q[i] != '0) && !ovf_q[i];
    end
  end

  // Scan starts just after the last winner so every lane gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N_LANES; k++) begin
`ifdef TOKEN_ARB_LANE0_PRIORITY_EN
      if (!win_vld
          && ((int'(ptr_q) + k) % N_LANES) != 0
          && req[(int'(ptr_q) + k) % N_LANES]) begin
`else
      if (!win_vld
          && req[(int'(ptr_q) + k) % N_LANES]) begin
`endif
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + k) % N_LANES);
      end
    end
`ifdef TOKEN_ARB_LANE0_PRIORITY_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  always_comb begin
`ifdef TOKEN_ARB_LANE0_PRIORITY_EN
    ptr_d = (win_vld && win_idx != '0) ? win_idx : ptr_q;
`else
    ptr_d = win_vld ? win_idx : ptr_q;
`endif
  end

  // Wide sum cannot wrap, so overflow is a plain compare.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < N_LANES; i++) begin
      nxt[i] = SW'(pend_q[i])
             + (a[i] ? SW'(MULT) : SW'(0))
             - ((win_vld && win_idx == IW'(i)) ? SW'(1) : SW'(0));
      pend_d[i] = '0;
      ovf_d[i]  = ovf_q[i];
      if (!ovf_q[i]) begin
        if (nxt[i] > SW'(MAX_PENDING)) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = nxt[i][CNT_W-1:0];
        end
      end
      busy_d = busy_d | (pend_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        pend_q[i] <= '0;
      end
      ovf_q   <= '0;
      ptr_q   <= IW'(N_LANES - 1);
      b_q     <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        pend_q[i] <= pend_d[i];
      end
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      b_q     <= win_vld;
      grant_q <= win_vld ? win_idx : '0;
      busy_q  <= busy_d;
    end
  end

  assign b        = b_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_token_stream_arbiter.sv
// Self-checking bench: constant vector table, reference-model scoreboard,
// and hand sequences for pattern, overflow and reset corners.
module tb_token_stream_arbiter;

  localparam int NL = 4;
  localparam int ML = 2;
  localparam int MP = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] a   = '0;
  logic          b;
  logic [1:0]    grant;
  logic          busy;
  logic [NL-1:0] overflow;

  int checks = 0;
  int errors = 0;

  token_stream_arbiter #(
    .N_LANES(NL), .MULT(ML),
    .MAX_PENDING(MP), .CNT_W(9)
  ) dut (
    .clk(clk), .rst(rst), .a(a),
    .b(b), .grant(grant), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [1:0] g;
    logic       busy;
    logic [3:0] ovf;
  } exp_t;

  typedef struct {
    logic       r;
    logic [3:0] a;
    logic       b;
    logic [1:0] g;
    logic       busy;
    logic [3:0] ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tv[$];

  int m_pend [NL];
  bit m_ovf  [NL];
  int m_ptr = NL - 1;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference behaviour: predicts outputs after the coming edge.
  task automatic model(input logic r, input logic [3:0] av);
    exp_t e;
    int   win;
    int   j;
    int   n;
    bit   rq [NL];
    e = '{1'b0, 2'd0, 1'b0, 4'd0};
    if (r) begin
      for (int i = 0; i < NL; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end
      m_ptr = NL - 1;
    end else begin
      for (int i = 0; i < NL; i++)
        rq[i] = (m_pend[i] > 0) && !m_ovf[i];
      win = -1;
`ifdef TOKEN_ARB_LANE0_PRIORITY_EN
      if (rq[0]) win = 0;
      for (int k = 1; k <= NL; k++) begin
        j = (m_ptr + k) % NL;
        if (win < 0 && j != 0 && rq[j]) win = j;
      end
      if (win > 0) m_ptr = win;
`else
      for (int k = 1; k <= NL; k++) begin
        j = (m_ptr + k) % NL;
        if (win < 0 && rq[j]) win = j;
      end
      if (win >= 0) m_ptr = win;
`endif
      e.b = (win >= 0);
      e.g = (win >= 0) ? 2'(win) : 2'd0;
      for (int i = 0; i < NL; i++) begin
        if (!m_ovf[i]) begin
          n = m_pend[i] + (av[i] ? ML : 0)
            - ((win == i) ? 1 : 0);
          if (n > MP) begin
            m_ovf[i]  = 1'b1;
            m_pend[i] = 0;
          end else begin
            m_pend[i] = n;
          end
        end
        if (m_pend[i] != 0) e.busy = 1'b1;
        e.ovf[i] = m_ovf[i];
      end
    end
    sb.push_back(e);
  endtask

  int cyc = 0;

  task automatic step(input logic r, input logic [3:0] av);
    exp_t e;
    @(negedge clk);
    rst = r;
    a   = av;
    model(r, av);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    checks++;
    if ({b, grant, busy, overflow}
        !== {e.b, e.g, e.busy, e.ovf}) begin
      errors++;
      $display("FAIL sb cyc=%0d got b=%b g=%0d busy=%b ovf=%b expected b=%b g=%0d busy=%b ovf=%b",
               cyc, b, grant, busy, overflow,
               e.b, e.g, e.busy, e.ovf);
    end
  endtask

  function automatic void tpush(
    input logic r, input logic [3:0] av,
    input logic eb, input logic [1:0] eg,
    input logic ebusy, input logic [3:0] eo);
    vec_t v;
    v = '{r, av, eb, eg, ebusy, eo};
    tv.push_back(v);
  endfunction

  logic [25:0] pat;
  int          nb;
  int          first_b;
  int          g1_cnt;
  int          g3_cnt;
  int          bad_g;

  initial begin
    // single-lane pulse
    tpush(1, 4'b0000, 0, 0, 0, 0);
    tpush(0, 4'b0001, 0, 0, 1, 0);
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 0, 0, 0);
    tpush(0, 4'b0000, 0, 0, 0, 0);
    // two lanes together
    tpush(1, 4'b0000, 0, 0, 0, 0);
    tpush(0, 4'b0101, 0, 0, 1, 0);
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 2, 1, 0);
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 2, 0, 0);
    tpush(0, 4'b0000, 0, 0, 0, 0);
    // lanes 0 and 1 contend
    tpush(1, 4'b0000, 0, 0, 0, 0);
    tpush(0, 4'b0011, 0, 0, 1, 0);
`ifdef TOKEN_ARB_LANE0_PRIORITY_EN
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 1, 1, 0);
    tpush(0, 4'b0000, 1, 1, 0, 0);
`else
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 1, 1, 0);
    tpush(0, 4'b0000, 1, 0, 1, 0);
    tpush(0, 4'b0000, 1, 1, 0, 0);
`endif
    tpush(0, 4'b0000, 0, 0, 0, 0);
    // token on the reset cycle is dropped
    tpush(1, 4'b0000, 0, 0, 0, 0);
    tpush(0, 4'b0001, 0, 0, 1, 0);
    tpush(1, 4'b0100, 0, 0, 0, 0);
    tpush(0, 4'b0000, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].a);
      checks++;
      if ({b, grant, busy, overflow}
          !== {tv[i].b, tv[i].g, tv[i].busy, tv[i].ovf}) begin
        errors++;
        $display("FAIL tbl[%0d] got b=%b g=%0d busy=%b ovf=%b expected b=%b g=%0d busy=%b ovf=%b",
                 i, b, grant, busy, overflow, tv[i].b,
                 tv[i].g, tv[i].busy, tv[i].ovf);
      end
    end

    // serial pattern on lane 0
    pat = 26'b10010011000110100001100100;
    step(1, 4'b0000);
    nb = 0;
    first_b = -1;
    bad_g = 0;
    for (int k = 0; k < 50; k++) begin
      step(1'b0, (k < 26) ? {3'b000, pat[25-k]} : 4'b0000);
      if (b) begin
        nb++;
        if (first_b < 0) first_b = k;
        if (grant != 2'd0) bad_g++;
      end
    end
    chk("pat_tokens", nb, 20);
    chk("pat_first_b", first_b, 1);
    chk("pat_grant", bad_g, 0);
    chk("pat_ovf", int'(overflow), 0);
    chk("pat_busy", int'(busy), 0);

    // lane 1 saturates
    step(1, 4'b0000);
    for (int k = 0; k < 400; k++) begin
      step(0, 4'b0010);
      if (k == 398)
        chk("ovf_before", int'(overflow), 0);
    end
    chk("ovf_at_400", int'(overflow), 4'b0010);
    g1_cnt = 0;
    g3_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, {(k == 0), 1'b0, k[0], 1'b0});
      if (b && grant == 2'd1) g1_cnt++;
      if (b && grant == 2'd3) g3_cnt++;
    end
    chk("ovf_sticky", int'(overflow), 4'b0010);
    chk("ovf_no_g1", g1_cnt, 0);
    chk("ovf_lane3", g3_cnt, 2);
    step(1, 4'b0010);
    chk("ovf_rst", int'(overflow), 0);

    // reset in the middle of a lane 2 drain
    for (int k = 0; k < 49; k++) step(0, 4'b0100);
    chk("mid_busy", int'(busy), 1);
    step(1, 4'b0000);
    chk("mid_rst",
        int'({b, grant, busy, overflow}), 0);
    step(0, 4'b0101);
    step(0, 4'b0000);
    chk("mid_first_b", int'(b), 1);
    chk("mid_first_g", int'(grant), 0);
    for (int k = 0; k < 6; k++) step(0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
